// File: rtl/mm_addr_decoder_n.sv
`default_nettype none
// ============================================================================
// Module   : mm_addr_decoder_n
// Purpose  : Parametrised memory-mapped address decoder / read-return mux.
//            Registers host requests, decodes the upper address bits into a
//            one-hot slave select, keeps a single read outstanding, returns
//            read data (or a synthetic error word on timeout / unmapped
//            access) and reports sticky error flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   iMM_WR_EN       : host write strobe
//   iMM_RD_EN       : host read strobe
//   iMM_ADDR        : host address
//   iMM_WR_DATA     : host write data
//   oMM_RD_DATA     : read response data (holds between responses)
//   oMM_RD_DATA_V   : read response valid, one-cycle pulse
//   oMM_BUSY        : a read is outstanding
//   oERR            : sticky flags {protocol, unmapped, timeout}
//   oERR_CNT        : {proto, unmapped, timeout} 16-bit saturating counters
//                     (only with MM_DECODE_ERR_CNT_EN defined)
//   iERR_CLR        : clears oERR (and the counters when present)
//   SLV_ADDR        : registered address shared by all slaves
//   SLV_WR_DATA     : registered write data shared by all slaves
//   SLV_WR_EN       : one-hot slave write strobe
//   SLV_RD_EN       : one-hot slave read strobe
//   SLV_RD_DATA     : packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   SLV_RD_DATA_V   : slave read-data valid
// Optional feature macro: MM_DECODE_ERR_CNT_EN
// ============================================================================
module mm_addr_decoder_n #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iMM_WR_EN,
    input  logic                        iMM_RD_EN,
    input  logic [ADDR_W-1:0]           iMM_ADDR,
    input  logic [DATA_W-1:0]           iMM_WR_DATA,
    output logic [DATA_W-1:0]           oMM_RD_DATA,
    output logic                        oMM_RD_DATA_V,
    output logic                        oMM_BUSY,
    output logic [2:0]                  oERR,
`ifdef MM_DECODE_ERR_CNT_EN
    output logic [47:0]                 oERR_CNT,
`endif
    input  logic                        iERR_CLR,
    output logic [ADDR_W-1:0]           SLV_ADDR,
    output logic [DATA_W-1:0]           SLV_WR_DATA,
    output logic [NUM_SLV-1:0]          SLV_WR_EN,
    output logic [NUM_SLV-1:0]          SLV_RD_EN,
    input  logic [NUM_SLV*DATA_W-1:0]   SLV_RD_DATA,
    input  logic [NUM_SLV-1:0]          SLV_RD_DATA_V
);

    localparam logic [SEL_W:0] c_num_slv  = (SEL_W+1)'(NUM_SLV);
    localparam logic [15:0]    c_tmo_last = 16'(TIMEOUT - 1);
    localparam logic [31:0]    c_tag_unmap = 32'h5555_AAAA;
    localparam logic [31:0]    c_tag_tmo   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Synthetic response word: tag in the top 32 bits, address in the bottom.
    function automatic logic [DATA_W-1:0] f_err_word(input logic [31:0] tag,
                                                     input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] w;
        w                  = '0;
        w[ADDR_W-1:0]      = addr;
        w[DATA_W-1 -: 32]  = tag;
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic              r_ren;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_addr  <= iMM_ADDR;
            r_wen   <= iMM_WR_EN;
            r_ren   <= iMM_RD_EN;
            r_wdata <= iMM_WR_DATA;
        end
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [15:0]       r_wait_cnt;
    logic [15:0]       w_wait_cnt_nxt;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] w_req_addr_nxt;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] w_rd_data_nxt;
    logic [2:0]        r_err;

    logic [SEL_W-1:0]  w_idx;
    logic              w_mapped;
    logic [NUM_SLV-1:0] w_dec;
    logic              w_busy;
    logic              w_wr_ok;
    logic              w_rd_go;
    logic              w_ev_tmo;
    logic              w_ev_unmap;
    logic              w_ev_proto;

    assign w_idx    = r_addr[ADDR_W-1 -: SEL_W];
    assign w_mapped = ({1'b0, w_idx} < c_num_slv);
    assign w_busy   = (r_state != S_IDLE);

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_dec[i] = w_mapped && (w_idx == SEL_W'(i));
        end
    end

    // Only an idle decoder accepts; a simultaneous write+read keeps the write.
    assign w_wr_ok = r_wen & ~w_busy;
    assign w_rd_go = r_ren & ~r_wen & ~w_busy;

    assign SLV_ADDR    = r_addr;
    assign SLV_WR_DATA = r_wdata;
    assign SLV_WR_EN   = w_dec & {NUM_SLV{w_wr_ok}};
    assign SLV_RD_EN   = w_dec & {NUM_SLV{w_rd_go}};

    // ------------------------------------------------------------------
    // Read-return mux. In IDLE the freshly decoded index is used so a
    // slave answering in the same cycle as its strobe is not missed.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]  w_mux_idx;
    logic              w_mux_v;
    logic [DATA_W-1:0] w_mux_data;

    assign w_mux_idx = (r_state == S_IDLE) ? w_idx : r_sel;

    always_comb begin
        w_mux_v    = 1'b0;
        w_mux_data = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_mux_idx == SEL_W'(i)) begin
                w_mux_v    = SLV_RD_DATA_V[i];
                w_mux_data = SLV_RD_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_wait_cnt <= '0;
            r_req_addr <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_rd_data  <= w_rd_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_wait_cnt_nxt = r_wait_cnt;
        w_req_addr_nxt = r_req_addr;
        w_rd_data_nxt  = r_rd_data;
        w_ev_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_go) begin
                    w_req_addr_nxt = r_addr;
                    if (!w_mapped) begin
                        w_state_nxt   = S_RESP;
                        w_rd_data_nxt = f_err_word(c_tag_unmap, r_addr);
                    end else if (w_mux_v) begin
                        w_state_nxt   = S_RESP;
                        w_rd_data_nxt = w_mux_data;
                    end else begin
                        w_state_nxt    = S_WAIT;
                        w_sel_nxt      = w_idx;
                        w_wait_cnt_nxt = '0;
                    end
                end
            end
            S_WAIT: begin
                // Real data has priority over a timeout in the same cycle.
                if (w_mux_v) begin
                    w_state_nxt   = S_RESP;
                    w_rd_data_nxt = w_mux_data;
                end else if (r_wait_cnt == c_tmo_last) begin
                    w_state_nxt   = S_RESP;
                    w_rd_data_nxt = f_err_word(c_tag_tmo, r_req_addr);
                    w_ev_tmo      = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign oMM_RD_DATA   = r_rd_data;
    assign oMM_RD_DATA_V = (r_state == S_RESP);
    assign oMM_BUSY      = w_busy;

    // ------------------------------------------------------------------
    // Error reporting
    // ------------------------------------------------------------------
    assign w_ev_unmap = ~w_busy & ~w_mapped & (r_wen | r_ren);
    assign w_ev_proto = (w_busy & (r_wen | r_ren)) | (r_wen & r_ren);

    always_ff @(posedge clk) begin
        if (rst || iERR_CLR) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | {w_ev_proto, w_ev_unmap, w_ev_tmo};
        end
    end

    assign oERR = r_err;

`ifdef MM_DECODE_ERR_CNT_EN
    function automatic logic [15:0] f_sat_inc(input logic [15:0] v, input logic ev);
        return (ev && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] r_cnt_tmo;
    logic [15:0] r_cnt_unmap;
    logic [15:0] r_cnt_proto;

    always_ff @(posedge clk) begin
        if (rst || iERR_CLR) begin
            r_cnt_tmo   <= '0;
            r_cnt_unmap <= '0;
            r_cnt_proto <= '0;
        end else begin
            r_cnt_tmo   <= f_sat_inc(r_cnt_tmo,   w_ev_tmo);
            r_cnt_unmap <= f_sat_inc(r_cnt_unmap, w_ev_unmap);
            r_cnt_proto <= f_sat_inc(r_cnt_proto, w_ev_proto);
        end
    end

    assign oERR_CNT = {r_cnt_proto, r_cnt_unmap, r_cnt_tmo};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mm_addr_decoder_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mm_addr_decoder_n
// Purpose  : Self-checking bench for mm_addr_decoder_n (NUM_SLV=3,
//            TIMEOUT=8). Directed cases followed by randomized transactions
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_addr_decoder_n;

    localparam int NUM_SLV = 3;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 64;
    localparam int SEL_W   = 4;
    localparam int TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      iMM_WR_EN;
    logic                      iMM_RD_EN;
    logic [ADDR_W-1:0]         iMM_ADDR;
    logic [DATA_W-1:0]         iMM_WR_DATA;
    logic [DATA_W-1:0]         oMM_RD_DATA;
    logic                      oMM_RD_DATA_V;
    logic                      oMM_BUSY;
    logic [2:0]                oERR;
    logic                      iERR_CLR;
    logic [ADDR_W-1:0]         SLV_ADDR;
    logic [DATA_W-1:0]         SLV_WR_DATA;
    logic [NUM_SLV-1:0]        SLV_WR_EN;
    logic [NUM_SLV-1:0]        SLV_RD_EN;
    logic [NUM_SLV*DATA_W-1:0] SLV_RD_DATA;
    logic [NUM_SLV-1:0]        SLV_RD_DATA_V;
`ifdef MM_DECODE_ERR_CNT_EN
    logic [47:0]               oERR_CNT;
`endif

    mm_addr_decoder_n #(
        .NUM_SLV (NUM_SLV),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .iMM_WR_EN     (iMM_WR_EN),
        .iMM_RD_EN     (iMM_RD_EN),
        .iMM_ADDR      (iMM_ADDR),
        .iMM_WR_DATA   (iMM_WR_DATA),
        .oMM_RD_DATA   (oMM_RD_DATA),
        .oMM_RD_DATA_V (oMM_RD_DATA_V),
        .oMM_BUSY      (oMM_BUSY),
        .oERR          (oERR),
`ifdef MM_DECODE_ERR_CNT_EN
        .oERR_CNT      (oERR_CNT),
`endif
        .iERR_CLR      (iERR_CLR),
        .SLV_ADDR      (SLV_ADDR),
        .SLV_WR_DATA   (SLV_WR_DATA),
        .SLV_WR_EN     (SLV_WR_EN),
        .SLV_RD_EN     (SLV_RD_EN),
        .SLV_RD_DATA   (SLV_RD_DATA),
        .SLV_RD_DATA_V (SLV_RD_DATA_V)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_fail   = 0;
    logic [2:0] exp_err = '0;
    int       exp_cnt[3] = '{0, 0, 0};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic int slave_of(input logic [ADDR_W-1:0] a);
        return int'(a >> (ADDR_W - SEL_W));
    endfunction

    function automatic logic [NUM_SLV-1:0] onehot_of(input logic [ADDR_W-1:0] a);
        int s;
        s = slave_of(a);
        return (s < NUM_SLV) ? NUM_SLV'(1 << s) : '0;
    endfunction

    // Each event is flagged at the end of the cycle it occurs in; a clear in
    // cycle clr_n wipes everything up to and including that cycle.
    task automatic apply_events(input int t_n, input int u_n, input int p_n, input int clr_n);
        int en[3];
        en = '{t_n, u_n, p_n};
        if (clr_n >= 0) begin
            exp_err = '0;
            exp_cnt = '{0, 0, 0};
        end
        for (int i = 0; i < 3; i++) begin
            if (en[i] >= 0 && (clr_n < 0 || en[i] > clr_n)) begin
                exp_err[i] = 1'b1;
                if (exp_cnt[i] < 65535) exp_cnt[i]++;
            end
        end
    endtask

    task automatic check_err(input string tag);
        check_val({tag, "_err"}, 64'(oERR), 64'(exp_err));
`ifdef MM_DECODE_ERR_CNT_EN
        check_val({tag, "_cnt"}, 64'(oERR_CNT),
                  {16'h0, 16'(exp_cnt[2]), 16'(exp_cnt[1]), 16'(exp_cnt[0])});
`endif
    endtask

    task automatic noise(input int excl);
        for (int i = 0; i < NUM_SLV; i++) begin
            SLV_RD_DATA[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            SLV_RD_DATA_V[i] = (i != excl) && ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic clear_drives();
        iMM_RD_EN = 1'b0;
        iMM_WR_EN = 1'b0;
        iERR_CLR  = 1'b0;
        rst       = 1'b0;
    endtask

    // ---------------- transactions ----------------
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit both);
        bit mapped;
        mapped = slave_of(a) < NUM_SLV;
        iMM_WR_EN = 1'b1; iMM_RD_EN = both; iMM_ADDR = a; iMM_WR_DATA = d;
        noise(-1);
        @(negedge clk);
        clear_drives();
        check_val("wr_strobe", 64'(SLV_WR_EN), 64'(onehot_of(a)));
        check_val("wr_no_rd",  64'(SLV_RD_EN), 64'h0);
        check_val("wr_addr",   64'(SLV_ADDR), 64'(a));
        check_val("wr_data",   SLV_WR_DATA, d);
        noise(-1);
        @(negedge clk);
        check_val("wr_strobe_end", 64'(SLV_WR_EN | SLV_RD_EN), 64'h0);
        check_val("wr_busy", 64'(oMM_BUSY), 64'h0);
        check_val("wr_no_rsp", 64'(oMM_RD_DATA_V), 64'h0);
        apply_events(-1, mapped ? -1 : 1, both ? 1 : -1, -1);
        check_err("wr");
    endtask

    task automatic do_clr();
        iERR_CLR = 1'b1;
        @(negedge clk);
        clear_drives();
        apply_events(-1, -1, -1, 0);
        check_err("clr");
    endtask

    // clr_n: -1 none, -2 random, else cycle number (1 = cycle after request)
    task automatic do_read(input logic [ADDR_W-1:0] a, input int k, input bit responds,
                           input bit inject, input int clr_arg);
        int slv, resp_n, inject_n, clr_n, v_count;
        bit mapped, real_data;
        logic [DATA_W-1:0] slv_data, exp_data;
        slv       = slave_of(a);
        mapped    = slv < NUM_SLV;
        real_data = mapped && responds && (k <= TIMEOUT);
        slv_data  = {$urandom, $urandom};
        if (!mapped) begin
            resp_n   = 2;
            exp_data = {32'h5555_AAAA, 32'h0} | 64'(a);
        end else if (real_data) begin
            resp_n   = 2 + k;
            exp_data = slv_data;
        end else begin
            resp_n   = 2 + TIMEOUT;
            exp_data = {32'hDEAD_BEEF, 32'h0} | 64'(a);
        end
        inject_n = inject ? $urandom_range(1, resp_n - 1) : -1;
        clr_n    = (clr_arg == -2) ? $urandom_range(1, resp_n + 3) : clr_arg;
        v_count  = 0;

        iMM_RD_EN = 1'b1; iMM_ADDR = a; iMM_WR_DATA = {$urandom, $urandom};
        noise(mapped ? slv : -1);
        for (int n = 1; n <= resp_n + 3; n++) begin
            @(negedge clk);
            clear_drives();
            if (n == 1) begin
                check_val("rd_strobe", 64'(SLV_RD_EN), 64'(onehot_of(a)));
                check_val("rd_no_wr",  64'(SLV_WR_EN), 64'h0);
                check_val("rd_addr",   64'(SLV_ADDR), 64'(a));
            end
            if (n == inject_n + 1)
                check_val("busy_drop", 64'(SLV_RD_EN | SLV_WR_EN), 64'h0);
            check_val("rd_busy", 64'(oMM_BUSY), 64'(n >= 2 && n <= resp_n));
            if (oMM_RD_DATA_V) begin
                v_count++;
                check_val("rsp_cycle", 64'(n), 64'(resp_n));
                check_val("rsp_data", oMM_RD_DATA, exp_data);
            end
            if (n == resp_n + 1)
                check_val("rsp_hold", oMM_RD_DATA, exp_data);
            // drive inputs for cycle n
            noise(mapped ? slv : -1);
            if (mapped && ((responds && n == 1 + k) || (!responds && n == resp_n + 1))) begin
                SLV_RD_DATA_V[slv] = 1'b1;
                SLV_RD_DATA[slv*DATA_W +: DATA_W] = slv_data;
            end
            if (n == inject_n) begin
                iMM_ADDR = 14'($urandom);
                if ($urandom_range(0, 1) == 0) iMM_RD_EN = 1'b1;
                else                           iMM_WR_EN = 1'b1;
            end
            if (n == clr_n) iERR_CLR = 1'b1;
        end
        @(negedge clk);
        clear_drives();
        check_val("rsp_count", 64'(v_count), 64'd1);
        apply_events((mapped && !real_data) ? resp_n - 1 : -1,
                     mapped ? -1 : 1,
                     inject ? inject_n + 1 : -1,
                     clr_n);
        check_err("rd");
    endtask

    task automatic do_read_rst(input logic [ADDR_W-1:0] a);
        int slv;
        slv = slave_of(a);
        iMM_RD_EN = 1'b1; iMM_ADDR = a;
        noise(slv);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            clear_drives();
            if (n == 1) check_val("rst_rd_strobe", 64'(SLV_RD_EN), 64'(onehot_of(a)));
            if (n == 2 || n == 3) check_val("rst_busy_pre", 64'(oMM_BUSY), 64'h1);
            if (n >= 4) begin
                check_val("rst_busy_post", 64'(oMM_BUSY), 64'h0);
                check_val("rst_no_rsp", 64'(oMM_RD_DATA_V), 64'h0);
            end
            noise(slv);
            if (n == 3) rst = 1'b1;
        end
        apply_events(-1, -1, -1, 0);
        check_err("rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iMM_WR_EN = 1'b0; iMM_RD_EN = 1'b0; iERR_CLR = 1'b0;
        iMM_ADDR = '0; iMM_WR_DATA = '0;
        SLV_RD_DATA = '0; SLV_RD_DATA_V = '0;
        iMM_WR_EN = 1'b1; iMM_ADDR = 14'h3FFF; iMM_WR_DATA = '1;
        repeat (3) @(negedge clk);
        check_val("reset_busy",  64'(oMM_BUSY), 64'h0);
        check_val("reset_rspv",  64'(oMM_RD_DATA_V), 64'h0);
        check_val("reset_rdata", oMM_RD_DATA, 64'h0);
        check_val("reset_err",   64'(oERR), 64'h0);
        check_val("reset_wr",    64'(SLV_WR_EN), 64'h0);
        check_val("reset_rd",    64'(SLV_RD_EN), 64'h0);
        check_val("reset_addr",  64'(SLV_ADDR), 64'h0);
        check_val("reset_wdata", SLV_WR_DATA, 64'h0);
        clear_drives();
        iMM_ADDR = '0; iMM_WR_DATA = '0;
        @(negedge clk);

        // directed cases (slave index = addr[13:10])
        do_write(14'h0005, 64'h1234, 1'b0);                 // slave 0
        do_read(14'h0410, 3, 1'b1, 1'b0, -1);               // slave 1, k=3
        do_read(14'h3FFF, 0, 1'b1, 1'b0, -1);               // unmapped -> err 010
        do_clr();
        do_read(14'h0923, 0, 1'b0, 1'b0, -1);               // slave 2 timeout
        do_clr();
        do_read(14'h0800, TIMEOUT, 1'b1, 1'b0, -1);         // valid on timeout cycle wins
        do_read(14'h0001, 0, 1'b1, 1'b0, -1);               // same-cycle return
        do_read(14'h0400, 5, 1'b1, 1'b1, -1);               // request while busy
        do_write(14'h0402, 64'hABCD, 1'b1);                 // wr+rd together
        do_write(14'h0C00, 64'h77, 1'b0);                   // unmapped write
        do_clr();
        do_read(14'h1000, 0, 1'b1, 1'b0, 1);                // clear beats same-cycle set
        do_read_rst(14'h0444);
        do_read(14'h0444, 2, 1'b1, 1'b0, -1);

        for (int it = 0; it < 80; it++) begin
            logic [ADDR_W-1:0] a;
            int op;
            op = $urandom_range(0, 9);
            a  = {SEL_W'($urandom_range(0, 4)), 10'($urandom)};
            if ($urandom_range(0, 7) == 0) a[ADDR_W-1 -: SEL_W] = 4'hF;
            if (op < 2)       do_write(a, {$urandom, $urandom}, 1'b0);
            else if (op == 2) do_write(a, {$urandom, $urandom}, 1'b1);
            else if (op == 3) do_clr();
            else              do_read(a, $urandom_range(0, TIMEOUT + 3),
                                      $urandom_range(0, 9) != 0,
                                      $urandom_range(0, 3) == 0,
                                      ($urandom_range(0, 7) == 0) ? -2 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
